// File: rtl/jtframe_joy_shifter.sv
// Emulates a pair of cascaded 74HC165 shift registers presenting two 6-button
// joysticks to an external serial reader whose clock and load pins are asynchronous to clk.
module jtframe_joy_shifter #(
    parameter int   TIMEOUT = 1024,
    parameter logic FILL    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] joy1_i,
    input  logic [5:0] joy2_i,
    input  logic       joy_clk_i,
    input  logic       joy_load_i,
    output logic       joy_data_o,
    output logic       busy,
    output logic [4:0] bit_cnt,
    output logic       frame_done,
    output logic       overrun
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOADED = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    load_sync_q;
    logic          clk_dly_q;
    logic          load_dly_q;
    logic          clk_rise_s;
    logic          load_s;
    logic          load_rise_s;

    logic [1:0]    state_q,  state_d;
    logic [15:0]   shift_q,  shift_d;
    logic [4:0]    cnt_q,    cnt_d;
    logic [TW-1:0] tmo_q,    tmo_d;
    logic          ovr_q,    ovr_d;
    logic          done_q,   done_d;
    logic          data_q;
    logic          busy_q;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        if (v == 5'd31) begin
            return 5'd31;
        end else begin
            return v + 5'd1;
        end
    endfunction

    // Two-flop synchronizers plus one delayed copy for edge detection; pins idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            load_sync_q <= 2'b11;
            clk_dly_q   <= 1'b1;
            load_dly_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], joy_clk_i};
            load_sync_q <= {load_sync_q[0], joy_load_i};
            clk_dly_q   <= clk_sync_q[1];
            load_dly_q  <= load_sync_q[1];
        end
    end

    assign clk_rise_s  = clk_sync_q[1] & ~clk_dly_q;
    assign load_s      = load_sync_q[1];
    assign load_rise_s = load_sync_q[1] & ~load_dly_q;

    // Next-state logic: a low load overrides everything, including a coincident clock edge.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;
        if (!load_s) begin
            state_d = ST_LOADED;
            shift_d = {4'b1111, joy2_i, joy1_i};
            cnt_d   = 5'd0;
            tmo_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOADED: begin
                    if (load_rise_s) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_LOADED;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise_s) begin
                        shift_d = {shift_q[14:0], FILL};
                        cnt_d   = sat_inc(cnt_q);
                        tmo_d   = '0;
                        done_d  = (cnt_q == 5'd15);
                        if (cnt_q >= 5'd16) begin
                            ovr_d = 1'b1;
                        end else begin
                            ovr_d = ovr_q;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Reader went quiet: abandon the frame and present idle-line data.
                        state_d = ST_IDLE;
                        shift_d = {16{FILL}};
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    shift_d = {16{FILL}};
                end
            endcase
        end
    end

    // State and output registers; joy_data_o tracks the next MSB so it equals the register MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= {16{FILL}};
            cnt_q   <= 5'd0;
            tmo_q   <= '0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= FILL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
            data_q  <= shift_d[15];
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign joy_data_o = data_q;
    assign busy       = busy_q;
    assign bit_cnt    = cnt_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;

endmodule

// File: doc/jtframe_joy_shifter.md
JTFRAME_JOY_SHIFTER -- requirements
Module: jtframe_joy_shifter

Interface
REQ-001 Parameter: TIMEOUT, 1024; number of clk cycles without a joy_clk_i rising edge that aborts a frame in progress.
REQ-002 Parameter: FILL, 1'b1; serial-in value shifted behind the frame, as for a cascaded 74HC165 with SER tied high.
REQ-003 Port: clk  input  1  system clock; all logic is on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: joy1_i  input  6  player 1, active-low: [5] fire2, [4] fire1, [3] up, [2] down, [1] left, [0] right.
REQ-006 Port: joy2_i  input  6  player 2, same bit map as joy1_i.
REQ-007 Port: joy_clk_i  input  1  serial clock from the joystick reader; asynchronous to clk.
REQ-008 Port: joy_load_i  input  1  parallel-load strobe from the reader, active-low; asynchronous to clk.
REQ-009 Port: joy_data_o  output  1  serial data to the reader.
REQ-010 Port: busy  output  1  high while state is LOADED or SHIFT.
REQ-011 Port: bit_cnt  output  5  number of bits shifted since the last load, saturating at 31.
REQ-012 Port: frame_done  output  1  one-cycle pulse when the 16th bit has been shifted out.
REQ-013 Port: overrun  output  1  sticky flag, set by any joy_clk_i rising edge after bit 16 of a frame; cleared by the next load.

Function
REQ-014 joy_clk_i and joy_load_i shall each pass through a 2-flop synchronizer; edge detection shall use the synchronized value and its 1-cycle delayed copy.
REQ-015 The frame word shall be frame[15:0] = {4'b1111, joy2_i, joy1_i}; bits shift out MSB first, so frame[15] is on joy_data_o first.
REQ-016 While synchronized load is low, the 16-bit shift register shall reload frame from the live inputs every cycle; the state shall be LOADED, bit_cnt 0, and overrun cleared.
REQ-017 joy_data_o shall always equal shift register bit 15, registered; a pin change reaches joy_data_o 3 clk cycles later (2 for the synchronizer, 1 for the register).
REQ-018 States: IDLE, LOADED, SHIFT.
REQ-019 Transitions: any -> LOADED when synchronized load is low.
REQ-020 Transitions: LOADED -> SHIFT on the load rising edge.
REQ-021 Transitions: SHIFT -> IDLE when TIMEOUT cycles pass with load high and no joy_clk_i rising edge.
REQ-022 In SHIFT, each synchronized joy_clk_i rising edge shall shift the register left by one, insert FILL at bit 0, and increment bit_cnt (saturating at 31).
REQ-023 frame_done shall pulse in the cycle after the shift that brings bit_cnt from 15 to 16.
REQ-024 In SHIFT with bit_cnt >= 16, a joy_clk_i rising edge shall set overrun; the register keeps shifting in FILL, so joy_data_o = FILL.
REQ-025 Simultaneous events: if load is low in the same cycle as a clock rising edge, the load wins; no shift, no bit_cnt increment, no frame_done.
REQ-026 In IDLE and in LOADED, joy_clk_i edges shall be ignored.
REQ-027 On entry to IDLE by timeout, the shift register shall fill with FILL, so joy_data_o = FILL; bit_cnt and overrun keep their values.
REQ-028 The timeout counter shall be wide enough for TIMEOUT and shall clear on every joy_clk_i rising edge and on load.

Reset
REQ-029 While rst_n is low: state IDLE; shift register all FILL; joy_data_o = FILL; busy 0; bit_cnt 0; frame_done 0; overrun 0; synchronizer flops 1 (idle-high pins).
REQ-030 Reset asserted mid-frame shall abort immediately; after release the block shall wait for a new load and drive no partial data.

Verification
REQ-031 Full frame: joy1_i=6'b111110, joy2_i=6'b011111, load pulse, then 16 joy_clk_i pulses at clk/8 -> sampled bits 1111_011111_111110, frame_done exactly once, overrun 0.
REQ-032 Overrun: after the 16 pulses of REQ-031, 2 more pulses -> joy_data_o=1 for both, overrun=1, bit_cnt=18; next load -> overrun=0, bit_cnt=0.
REQ-033 Live load: hold load low, change joy1_i[4] from 1 to 0 -> joy_data_o unchanged until shifting; after load release and 11 pulses, joy_data_o=0 (frame bit 4).
REQ-034 Collision: assert load low in the same clk cycle as a synchronized joy_clk_i rise at bit_cnt=5 -> bit_cnt=0, register reloaded, no shift.
REQ-035 Timeout with TIMEOUT=64: after load plus 3 pulses, 64 idle cycles -> state IDLE, busy=0, joy_data_o=1; further joy_clk_i pulses have no effect.
REQ-036 Reset mid-frame: rst_n low at bit_cnt=7 -> all outputs take REQ-029 values asynchronously; after release, clock pulses without a load give joy_data_o=1 and no frame_done.
